// File: rtl/handshake_pkg.sv
// Shared helpers for elastic-handshake blocks: index-width math and the
// grant record produced by the round-robin priority selector.
package handshake_pkg;

  // A single requester still gets a 1-bit index so port widths never collapse to zero.
  localparam int MIN_INDEX_WIDTH = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((32'sd1 <<< i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int index_width(input int n);
    return (clog2(n) < MIN_INDEX_WIDTH) ? MIN_INDEX_WIDTH : clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Done as one priority encode over {req, req & mask_from_ptr}.
module rr_priority_select
  import handshake_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = index_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0]  req,
  input  logic [INDEX_WIDTH-1:0] ptr,
  output logic [NUM_INPUTS-1:0]  grant,
  output logic [INDEX_WIDTH-1:0] grant_idx,
  output logic                   any
);

  logic [NUM_INPUTS-1:0]   mask;
  logic [2*NUM_INPUTS-1:0] dbl;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_mask
      assign mask[gi] = (32'(gi) >= 32'(ptr));
    end
  endgenerate

  // Low half holds requests at/after ptr; the high half is the wrapped fallback.
  assign dbl = {req, req & mask};
  assign any = |req;

  always_comb begin
    logic found;
    int   k;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int j = 0; j < 2 * NUM_INPUTS; j++) begin
      if (!found && dbl[j]) begin
        found     = 1'b1;
        k         = (j >= NUM_INPUTS) ? j - NUM_INPUTS : j;
        grant_idx = INDEX_WIDTH'(k);
        grant[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_dataless.sv
// Dataless N-to-1 round-robin arbiter: one registered output slot carrying the
// winner's index, full throughput (drain and refill in the same cycle).
module rr_arbiter_dataless
  import handshake_pkg::*;
#(
  parameter  int NUM_INPUTS  = 4,
  localparam int INDEX_WIDTH = index_width(NUM_INPUTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  ins_valid,
  output logic [NUM_INPUTS-1:0]  ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [INDEX_WIDTH-1:0] index
);

  logic                   valid_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [INDEX_WIDTH-1:0] ptr;

  logic [NUM_INPUTS-1:0]  grant;
  logic [INDEX_WIDTH-1:0] grant_idx;
  logic                   any;
  logic                   load;

  rr_priority_select #(
    .NUM_INPUTS  (NUM_INPUTS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_sel (
    .req       (ins_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign load = ~valid_q | outs_ready;

  // rst gates ready so nothing is acknowledged while reset is held.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
      assign ins_ready[gi] = rst & load & any & grant[gi];
    end
  endgenerate

  assign outs_valid = valid_q;
  assign index      = index_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      index_q <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (any) begin
        valid_q <= 1'b1;
        index_q <= grant_idx;
        // Pointer moves only on a grant, to just past the winner.
        ptr     <= (32'(grant_idx) == 32'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter_dataless.sv
// Randomized and directed checks of rr_arbiter_dataless against a
// queue-free round-robin reference model (modular scan from a priority pointer).
module tb_rr_arbiter_dataless;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] ins_valid;
  logic [N-1:0] ins_ready;
  logic         outs_valid;
  logic         outs_ready;
  logic [1:0]   index;

  rr_arbiter_dataless #(.NUM_INPUTS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .index      (index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cnt, errs;
  // Reference model: slot occupancy, held index, and the highest-priority input.
  int m_valid, m_idx, m_ptr;
  int last_grant;
  logic [N-1:0] seen_ready;
  logic         seen_ov;
  logic [1:0]   seen_idx;

  function automatic int exp_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int first_one(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_ptr = 0;
  endtask

  // Entered just after a falling edge; drives, checks, crosses one rising edge.
  task automatic step(input logic [N-1:0] v, input logic r);
    int g;
    logic [N-1:0] er;
    ins_valid = v; outs_ready = r;
    #2;
    g  = exp_grant(v, m_ptr);
    er = '0;
    if (g >= 0 && (m_valid == 0 || r)) er[g] = 1'b1;
    seen_ready = ins_ready; seen_ov = outs_valid; seen_idx = index;
    cnt++;
    if (ins_ready !== er) begin
      errs++; $display("FAIL step ins_ready: got %b want %b (v=%b r=%b)", ins_ready, er, v, r);
    end
    cnt++;
    if (outs_valid !== (m_valid != 0)) begin
      errs++; $display("FAIL step outs_valid: got %b want %0d", outs_valid, m_valid);
    end
    if (m_valid != 0) begin
      cnt++;
      if (index !== 2'(m_idx)) begin
        errs++; $display("FAIL step index: got %0d want %0d", index, m_idx);
      end
    end
    @(posedge clk);
    last_grant = -1;
    if (m_valid == 0 || r) begin
      if (g >= 0) begin
        m_valid = 1; m_idx = g; m_ptr = (g + 1) % N; last_grant = g;
      end else m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; ins_valid = '1; outs_ready = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #2;
      cnt++;
      if (outs_valid !== 1'b0 || ins_ready !== '0 || index !== 2'd0) begin
        errs++; $display("FAIL reset_hold: ov=%b rdy=%b idx=%0d want 0/0000/0", outs_valid, ins_ready, index);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_rotation();
    int want[6] = '{0, 1, 2, 3, 0, 1};
    for (int c = 0; c < 6; c++) begin
      step('1, 1'b1);
      cnt++;
      if (last_grant != want[c]) begin
        errs++; $display("FAIL rotation grant %0d: got %0d want %0d", c, last_grant, want[c]);
      end
      cnt++;
      if (outs_valid !== 1'b1 || index !== 2'(want[c])) begin
        errs++; $display("FAIL rotation outs %0d: ov=%b idx=%0d want 1/%0d", c, outs_valid, index, want[c]);
      end
    end
  endtask

  task automatic test_sparse_wrap();
    step(4'b0100, 1'b1);
    cnt++;
    if (last_grant != 2) begin errs++; $display("FAIL sparse_setup: got %0d want 2", last_grant); end
    step(4'b0101, 1'b1);
    cnt++;
    if (last_grant != 0) begin errs++; $display("FAIL sparse_wrap: got %0d want 0", last_grant); end
    step(4'b0101, 1'b1);
    cnt++;
    if (last_grant != 2) begin errs++; $display("FAIL sparse_next: got %0d want 2", last_grant); end
  endtask

  task automatic test_backpressure();
    step(4'b0010, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(4'b0010, 1'b0);
      cnt++;
      if (seen_ready !== '0 || seen_ov !== 1'b1 || seen_idx !== 2'd1) begin
        errs++; $display("FAIL backpressure %0d: rdy=%b ov=%b idx=%0d want 0000/1/1", c, seen_ready, seen_ov, seen_idx);
      end
    end
    step(4'b0010, 1'b1);
    cnt++;
    if (seen_ready !== 4'b0010 || seen_ov !== 1'b1) begin
      errs++; $display("FAIL drain_and_grant: rdy=%b ov=%b want 0010/1", seen_ready, seen_ov);
    end
  endtask

  task automatic test_idle_drain();
    step(4'b1000, 1'b1);
    cnt++;
    if (last_grant != 3) begin errs++; $display("FAIL idle_grant: got %0d want 3", last_grant); end
    step('0, 1'b1);
    step('0, 1'b1);
    cnt++;
    if (seen_ov !== 1'b0) begin errs++; $display("FAIL idle_drop: ov=%b want 0", seen_ov); end
    step('0, 1'b1);
    step('1, 1'b1);
    cnt++;
    if (last_grant != 0) begin errs++; $display("FAIL idle_ptr_hold: got %0d want 0", last_grant); end
  endtask

  task automatic test_reset_mid_transfer();
    step(4'b0100, 1'b1);
    ins_valid = '1; outs_ready = 1'b1;
    #2;
    cnt++;
    if (outs_valid !== 1'b1 || index !== 2'd2) begin
      errs++; $display("FAIL mid_setup: ov=%b idx=%0d want 1/2", outs_valid, index);
    end
    rst = 1'b0;
    #1;
    cnt++;
    if (outs_valid !== 1'b0 || index !== 2'd0 || ins_ready !== '0) begin
      errs++; $display("FAIL async_reset: ov=%b idx=%0d rdy=%b want 0/0/0000", outs_valid, index, ins_ready);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random_fairness();
    logic [N-1:0] held, v;
    logic r;
    int waits[N];
    int tin, tout, g;
    held = '0; tin = 0; tout = 0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      v = held | N'($urandom & $urandom);
      r = ($urandom_range(3) != 0);
      step(v, r);
      cnt++;
      if ($countones(seen_ready) > 1) begin
        errs++; $display("FAIL onehot cycle %0d: rdy=%b", c, seen_ready);
      end
      if (seen_ready != '0) begin
        g = first_one(seen_ready);
        for (int i = 0; i < N; i++) if (v[i] && i != g) waits[i]++;
        cnt++;
        if (waits[g] > N - 1) begin
          errs++; $display("FAIL fairness: input %0d waited %0d grants, limit %0d", g, waits[g], N - 1);
        end
        waits[g] = 0;
        tin++;
      end
      if (seen_ov && r) tout++;
      held = v & ~seen_ready;
    end
    cnt++;
    if (tin != tout + int'(outs_valid)) begin
      errs++; $display("FAIL token_count: in=%0d out=%0d held=%b", tin, tout, outs_valid);
    end
  endtask

  initial begin
    cnt = 0; errs = 0; last_grant = -1;
    rst = 1'b0; ins_valid = '0; outs_ready = 1'b0;
    test_reset();
    test_rotation();
    test_sparse_wrap();
    test_backpressure();
    test_idle_drain();
    test_reset_mid_transfer();
    test_random_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end

endmodule
